// File: rtl/pump_load_sequencer_pkg.sv
// Shared types and constants for the data-pump download sequencer.
//   pump_state_e : sequencer states
//   PUMP_*       : status codes reported on pump_o
//   max3()       : elaboration helper for sizing the shared cycle timer
package pump_load_sequencer_pkg;

  typedef enum logic [2:0] {
    PS_POWERON = 3'd0,
    PS_ARMED   = 3'd1,
    PS_LOAD    = 3'd2,
    PS_WRITE   = 3'd3,
    PS_RELEASE = 3'd4,
    PS_ERROR   = 3'd5
  } pump_state_e;

  localparam logic [7:0] PUMP_BOOT   = 8'h3F;
  localparam logic [7:0] PUMP_ACTIVE = 8'hFF;
  localparam logic [7:0] PUMP_ERROR  = 8'hE0;

  // Largest of three cycle counts, used to size the shared timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pump_load_sequencer_if.sv
// Memory write port between the download sequencer and the SDRAM arbiter.
//   mem_req  : write request, held until acknowledged (or abandoned on reset)
//   mem_addr : byte address
//   mem_data : byte data
//   mem_ack  : one-cycle write-complete pulse
// master = sequencer side, slave = arbiter side.
interface pump_load_sequencer_if #(
  parameter int unsigned ADDR_W = 22
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack;

  modport master (output mem_req, output mem_addr, output mem_data, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_data, output mem_ack);
endinterface

// File: rtl/pump_load_sequencer_cycle_timer.sv
// Loadable down-counter with a zero flag; shared by the power-on hold-off,
// the core-release delay and the write-ack timeout.
//   clk_i, reset_i : clock, synchronous active-high reset (loads RESET_VAL)
//   load_i         : load load_val_i (wins over dec_i)
//   dec_i          : decrement, stops at zero
//   zero_c         : combinational count==0 flag
module pump_load_sequencer_cycle_timer #(
  parameter int unsigned WIDTH     = 17,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c
);

  logic [WIDTH-1:0] count_q;

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= WIDTH'(RESET_VAL);
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/pump_load_sequencer.sv
// Sequences the data-pump download from the OSD microcontroller into SDRAM:
// power-on hold-off, core reset while loading, one-byte buffered memory
// writes with an ack timeout, and the pump status code.
// Ports:
//   clk_i, reset_i         : clock, synchronous active-high reset
//   download_i             : download-active level from the microcontroller
//   dl_wr_i/dl_addr_i/dl_data_i : byte strobe/address/data (honoured only while dl_wait_o=0)
//   dl_wait_o              : backpressure to the SPI receiver
//   mem                    : memory write port (master side)
//   core_reset_o           : reset to the MSX core
//   pump_o                 : status 3F boot/armed, FF loading, E0 error
//   byte_count_o           : bytes acknowledged this download, saturating
//   done_o                 : one-cycle pulse on RELEASE -> ARMED
//   checksum_o             : (PUMP_CHECKSUM_EN only) mod-2^16 sum of acknowledged bytes
// Build option: define PUMP_CHECKSUM_EN to add checksum_o.
module pump_load_sequencer
  import pump_load_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W         = 22,
  parameter int unsigned POWERON_CYCLES = 65535,
  parameter int unsigned RELEASE_CYCLES = 256,
  parameter int unsigned ACK_TIMEOUT    = 1023
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 download_i,
  input  logic                 dl_wr_i,
  input  logic [ADDR_W-1:0]    dl_addr_i,
  input  logic [7:0]           dl_data_i,
  output logic                 dl_wait_o,
  pump_load_sequencer_if.master mem,
  output logic                 core_reset_o,
  output logic [7:0]           pump_o,
  output logic [ADDR_W:0]      byte_count_o,
  output logic                 done_o
`ifdef PUMP_CHECKSUM_EN
  ,
  output logic [15:0]          checksum_o
`endif
);

  localparam int unsigned TIMER_W = $clog2(max3(POWERON_CYCLES, RELEASE_CYCLES, ACK_TIMEOUT)) + 1;
  localparam int unsigned CNT_W   = ADDR_W + 1;

  pump_state_e        state_q, state_d;
  logic               download_q;
  logic               wr_accept_c;
  logic               dl_rise_c;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_dec;
  logic               timer_zero_c;

  logic               dl_wait_d;
  logic               core_reset_d;
  logic [7:0]         pump_d;
  logic [CNT_W-1:0]   byte_count_d;
  logic               done_d;
  logic               mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         mem_data_d;
`ifdef PUMP_CHECKSUM_EN
  logic [15:0]        checksum_d;
`endif

  // A strobe only counts when the receiver was told it may send.
  assign wr_accept_c = dl_wr_i && !dl_wait_o;
  assign dl_rise_c   = download_i && !download_q;

  pump_load_sequencer_cycle_timer #(
    .WIDTH     (TIMER_W),
    .RESET_VAL (POWERON_CYCLES - 1)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .dec_i      (timer_dec),
    .zero_c     (timer_zero_c)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= PS_POWERON;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PS_POWERON: if (timer_zero_c) state_d = PS_ARMED;
      PS_ARMED:   if (download_i) state_d = PS_LOAD;
      PS_LOAD: begin
        if (wr_accept_c)     state_d = PS_WRITE;
        else if (!download_i) state_d = PS_RELEASE;
      end
      PS_WRITE: begin
        if (mem.mem_ack)       state_d = PS_LOAD;
        else if (timer_zero_c) state_d = PS_ERROR;
      end
      PS_RELEASE: begin
        if (timer_zero_c)    state_d = PS_ARMED;
        else if (download_i) state_d = PS_LOAD;
      end
      PS_ERROR:   if (dl_rise_c) state_d = PS_LOAD;
      default:    state_d = PS_POWERON;
    endcase
  end

  // Next values of the registered outputs and timer control.
  always_comb begin
    dl_wait_d    = dl_wait_o;
    core_reset_d = core_reset_o;
    pump_d       = pump_o;
    byte_count_d = byte_count_o;
    done_d       = 1'b0;
    mem_req_d    = mem.mem_req;
    mem_addr_d   = mem.mem_addr;
    mem_data_d   = mem.mem_data;
`ifdef PUMP_CHECKSUM_EN
    checksum_d   = checksum_o;
`endif
    timer_load   = 1'b0;
    timer_val    = '0;
    timer_dec    = 1'b0;

    case (state_q)
      PS_POWERON: begin
        if (timer_zero_c) begin
          core_reset_d = 1'b0;
          pump_d       = PUMP_BOOT;
          dl_wait_d    = 1'b1;
        end else begin
          timer_dec = 1'b1;
        end
      end
      PS_ARMED: begin
        if (download_i) begin
          core_reset_d = 1'b1;
          pump_d       = PUMP_ACTIVE;
          byte_count_d = '0;
`ifdef PUMP_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      PS_LOAD: begin
        if (wr_accept_c) begin
          mem_addr_d = dl_addr_i;
          mem_data_d = dl_data_i;
          mem_req_d  = 1'b1;
          dl_wait_d  = 1'b1;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(ACK_TIMEOUT);
        end else if (!download_i) begin
          dl_wait_d  = 1'b1;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(RELEASE_CYCLES - 1);
        end else begin
          // Opens one clock after entering LOAD, so a fresh ack never
          // overlaps the next strobe.
          dl_wait_d = 1'b0;
        end
      end
      PS_WRITE: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          if (byte_count_o != '1) byte_count_d = byte_count_o + CNT_W'(1);
`ifdef PUMP_CHECKSUM_EN
          checksum_d = checksum_o + 16'(mem.mem_data);
`endif
        end else if (timer_zero_c) begin
          mem_req_d = 1'b0;
          pump_d    = PUMP_ERROR;
        end else begin
          timer_dec = 1'b1;
        end
      end
      PS_RELEASE: begin
        if (timer_zero_c) begin
          core_reset_d = 1'b0;
          pump_d       = PUMP_BOOT;
          done_d       = 1'b1;
        end else if (download_i) begin
          byte_count_d = '0;
        end else begin
          timer_dec = 1'b1;
        end
      end
      PS_ERROR: begin
        if (dl_rise_c) begin
          pump_d       = PUMP_ACTIVE;
          byte_count_d = '0;
`ifdef PUMP_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Output registers; a reset drops any outstanding request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      download_q   <= 1'b0;
      dl_wait_o    <= 1'b1;
      core_reset_o <= 1'b1;
      pump_o       <= PUMP_BOOT;
      byte_count_o <= '0;
      done_o       <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_data <= '0;
`ifdef PUMP_CHECKSUM_EN
      checksum_o   <= '0;
`endif
    end else begin
      download_q   <= download_i;
      dl_wait_o    <= dl_wait_d;
      core_reset_o <= core_reset_d;
      pump_o       <= pump_d;
      byte_count_o <= byte_count_d;
      done_o       <= done_d;
      mem.mem_req  <= mem_req_d;
      mem.mem_addr <= mem_addr_d;
      mem.mem_data <= mem_data_d;
`ifdef PUMP_CHECKSUM_EN
      checksum_o   <= checksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_pump_load_sequencer.sv
// Testbench for pump_load_sequencer: scenario tasks with inline checks
// against a small model (expected byte count / checksum, cycle constants).
module tb_pump_load_sequencer;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned PON     = 16;
  localparam int unsigned REL     = 4;
  localparam int unsigned ACK_TO  = 8;
  localparam int unsigned CNT_MAX = (1 << (ADDR_W + 1)) - 1;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              download_i = 1'b0;
  logic              dl_wr_i = 1'b0;
  logic [ADDR_W-1:0] dl_addr_i = '0;
  logic [7:0]        dl_data_i = '0;
  logic              dl_wait_o;
  logic              core_reset_o;
  logic [7:0]        pump_o;
  logic [ADDR_W:0]   byte_count_o;
  logic              done_o;
`ifdef PUMP_CHECKSUM_EN
  logic [15:0]       checksum_o;
  logic [15:0]       exp_sum;
`endif

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  pump_load_sequencer_if #(.ADDR_W(ADDR_W)) mem_if ();

  pump_load_sequencer #(
    .ADDR_W         (ADDR_W),
    .POWERON_CYCLES (PON),
    .RELEASE_CYCLES (REL),
    .ACK_TIMEOUT    (ACK_TO)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .download_i   (download_i),
    .dl_wr_i      (dl_wr_i),
    .dl_addr_i    (dl_addr_i),
    .dl_data_i    (dl_data_i),
    .dl_wait_o    (dl_wait_o),
    .mem          (mem_if),
    .core_reset_o (core_reset_o),
    .pump_o       (pump_o),
    .byte_count_o (byte_count_o),
    .done_o       (done_o)
`ifdef PUMP_CHECKSUM_EN
    ,
    .checksum_o   (checksum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_start();
    exp_count = 0;
`ifdef PUMP_CHECKSUM_EN
    exp_sum = 16'h0;
`endif
  endtask

  // Wait (bounded) for the receiver to be allowed to send.
  task automatic wait_ready();
    int n = 0;
    while (dl_wait_o !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (dl_wait_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_ready dl_wait_o=%b expected 0", dl_wait_o);
    end
  endtask

  // Send one byte and acknowledge it 'delay' clocks after the request appears.
  task automatic write_byte(input logic [7:0] a, input logic [7:0] d,
                            input int unsigned delay, input logic fall);
    wait_ready();
    dl_wr_i = 1'b1;
    dl_addr_i = a;
    dl_data_i = d;
    if (fall) download_i = 1'b0;
    step();
    dl_wr_i = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== a || mem_if.mem_data !== d) begin
      errors++;
      $display("FAIL req_issue req=%b addr=%h data=%h expected 1 %h %h",
               mem_if.mem_req, mem_if.mem_addr, mem_if.mem_data, a, d);
    end
    for (int k = 0; k < int'(delay); k++) begin
      step();
      checks++;
      if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== a || mem_if.mem_data !== d) begin
        errors++;
        $display("FAIL req_hold req=%b addr=%h data=%h expected 1 %h %h",
                 mem_if.mem_req, mem_if.mem_addr, mem_if.mem_data, a, d);
      end
    end
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
    exp_count = (exp_count >= int'(CNT_MAX)) ? int'(CNT_MAX) : exp_count + 1;
`ifdef PUMP_CHECKSUM_EN
    exp_sum = exp_sum + 16'(d);
`endif
    checks++;
    if (mem_if.mem_req !== 1'b0 || dl_wait_o !== 1'b1) begin
      errors++;
      $display("FAIL ack_drop req=%b dl_wait=%b expected 0 1", mem_if.mem_req, dl_wait_o);
    end
  endtask

  task automatic check_totals(input string tag);
    checks++;
    if (byte_count_o !== (ADDR_W+1)'(exp_count)) begin
      errors++;
      $display("FAIL %s byte_count=%0d expected %0d", tag, byte_count_o, exp_count);
    end
`ifdef PUMP_CHECKSUM_EN
    checks++;
    if (checksum_o !== exp_sum) begin
      errors++;
      $display("FAIL %s checksum=%h expected %h", tag, checksum_o, exp_sum);
    end
`endif
  endtask

  // Drop download and expect done after the release delay.
  task automatic end_download();
    int n = 0;
    download_i = 1'b0;
    while (done_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (done_o !== 1'b1 || pump_o !== 8'h3F || core_reset_o !== 1'b0) begin
      errors++;
      $display("FAIL end_download done=%b pump=%h core_reset=%b expected 1 3f 0",
               done_o, pump_o, core_reset_o);
    end
  endtask

  task automatic poweron_run(input logic dl_level);
    download_i = dl_level;
    for (int i = 1; i <= int'(PON); i++) begin
      step();
      checks++;
      if (core_reset_o !== ((i < int'(PON)) ? 1'b1 : 1'b0) || pump_o !== 8'h3F) begin
        errors++;
        $display("FAIL poweron clk %0d core_reset=%b pump=%h expected %b 3f",
                 i, core_reset_o, pump_o, (i < int'(PON)));
      end
    end
    download_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    checks++;
    if (core_reset_o !== 1'b1 || pump_o !== 8'h3F || dl_wait_o !== 1'b1 ||
        mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 8'h00 || mem_if.mem_data !== 8'h00 ||
        byte_count_o !== 9'd0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values core_reset=%b pump=%h wait=%b req=%b addr=%h data=%h cnt=%0d done=%b",
               core_reset_o, pump_o, dl_wait_o, mem_if.mem_req, mem_if.mem_addr,
               mem_if.mem_data, byte_count_o, done_o);
    end
    poweron_run(1'b0);
  endtask

  task automatic test_download();
    download_i = 1'b1;
    step();
    model_start();
    checks++;
    if (core_reset_o !== 1'b1 || pump_o !== 8'hFF || byte_count_o !== 9'd0) begin
      errors++;
      $display("FAIL load_entry core_reset=%b pump=%h cnt=%0d expected 1 ff 0",
               core_reset_o, pump_o, byte_count_o);
    end
    write_byte(8'h00, 8'hA5, 2, 1'b0);
    write_byte(8'h01, 8'h5A, 2, 1'b0);
    write_byte(8'h02, 8'hFF, 2, 1'b0);
    check_totals("three_bytes");
`ifdef PUMP_CHECKSUM_EN
    checks++;
    if (checksum_o !== 16'h01FE) begin
      errors++;
      $display("FAIL checksum_fixed checksum=%h expected 01fe", checksum_o);
    end
`endif
    download_i = 1'b0;
    for (int k = 1; k <= int'(REL) + 1; k++) begin
      step();
      checks++;
      if (core_reset_o !== ((k <= int'(REL)) ? 1'b1 : 1'b0) ||
          done_o !== ((k == int'(REL) + 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL release clk %0d core_reset=%b done=%b", k, core_reset_o, done_o);
      end
    end
    step();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b expected 0", done_o);
    end
  endtask

  task automatic test_random_downloads();
    for (int r = 0; r < 4; r++) begin
      int unsigned nb;
      download_i = 1'b1;
      step();
      model_start();
      nb = $urandom_range(1, 10);
      for (int b = 0; b < int'(nb); b++) begin
        write_byte(8'($urandom), 8'($urandom), $urandom_range(0, ACK_TO - 1), 1'b0);
      end
      check_totals("random_round");
      end_download();
    end
  endtask

  task automatic test_saturation();
    download_i = 1'b1;
    step();
    model_start();
    for (int b = 0; b < int'(CNT_MAX) + 4; b++) begin
      write_byte(8'($urandom), 8'($urandom), 0, 1'b0);
    end
    check_totals("saturation");
    end_download();
  endtask

  task automatic test_timeout();
    download_i = 1'b1;
    step();
    wait_ready();
    dl_wr_i = 1'b1;
    dl_addr_i = 8'h33;
    dl_data_i = 8'hC3;
    step();
    dl_wr_i = 1'b0;
    for (int k = 1; k <= int'(ACK_TO) + 1; k++) begin
      step();
      checks++;
      if (mem_if.mem_req !== ((k <= int'(ACK_TO)) ? 1'b1 : 1'b0) ||
          pump_o !== ((k <= int'(ACK_TO)) ? 8'hFF : 8'hE0)) begin
        errors++;
        $display("FAIL timeout clk %0d req=%b pump=%h", k, mem_if.mem_req, pump_o);
      end
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (pump_o !== 8'hE0 || core_reset_o !== 1'b1 || dl_wait_o !== 1'b1) begin
      errors++;
      $display("FAIL error_hold pump=%h core_reset=%b wait=%b expected e0 1 1",
               pump_o, core_reset_o, dl_wait_o);
    end
    download_i = 1'b0;
    step();
    download_i = 1'b1;
    step();
    checks++;
    if (pump_o !== 8'hFF || core_reset_o !== 1'b1) begin
      errors++;
      $display("FAIL error_exit pump=%h core_reset=%b expected ff 1", pump_o, core_reset_o);
    end
    step();
    checks++;
    if (dl_wait_o !== 1'b0) begin
      errors++;
      $display("FAIL error_to_load dl_wait=%b expected 0", dl_wait_o);
    end
    end_download();
  endtask

  task automatic test_wr_with_fall();
    download_i = 1'b1;
    step();
    model_start();
    write_byte(8'($urandom), 8'($urandom), 2, 1'b1);
    check_totals("wr_with_fall");
    for (int k = 1; k <= int'(REL) + 1; k++) begin
      step();
      checks++;
      if (done_o !== ((k == int'(REL) + 1) ? 1'b1 : 1'b0) ||
          core_reset_o !== ((k <= int'(REL)) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL fall_release clk %0d done=%b core_reset=%b", k, done_o, core_reset_o);
      end
    end
  endtask

  task automatic test_redownload();
    download_i = 1'b1;
    step();
    model_start();
    write_byte(8'h10, 8'h22, 1, 1'b0);
    download_i = 1'b0;
    step();
    step();
    download_i = 1'b1;
    step();
    checks++;
    if (byte_count_o !== 9'd0 || pump_o !== 8'hFF || core_reset_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL redownload cnt=%0d pump=%h core_reset=%b done=%b expected 0 ff 1 0",
               byte_count_o, pump_o, core_reset_o, done_o);
    end
    step();
    checks++;
    if (dl_wait_o !== 1'b0) begin
      errors++;
      $display("FAIL redownload_load dl_wait=%b expected 0", dl_wait_o);
    end
    end_download();
  endtask

  task automatic test_wr_in_write();
    logic [7:0] a, d;
    a = 8'($urandom);
    d = 8'($urandom);
    download_i = 1'b1;
    step();
    wait_ready();
    dl_wr_i = 1'b1;
    dl_addr_i = a;
    dl_data_i = d;
    step();
    dl_wr_i = 1'b0;
    step();
    dl_wr_i = 1'b1;
    dl_addr_i = ~a;
    dl_data_i = ~d;
    step();
    dl_wr_i = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== a || mem_if.mem_data !== d) begin
      errors++;
      $display("FAIL wr_in_write req=%b addr=%h data=%h expected 1 %h %h",
               mem_if.mem_req, mem_if.mem_addr, mem_if.mem_data, a, d);
    end
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (mem_if.mem_req !== 1'b0 || byte_count_o !== 9'd1 || mem_if.mem_addr !== a) begin
      errors++;
      $display("FAIL wr_in_write_count req=%b cnt=%0d addr=%h expected 0 1 %h",
               mem_if.mem_req, byte_count_o, mem_if.mem_addr, a);
    end
    end_download();
  endtask

  task automatic test_reset_mid();
    download_i = 1'b1;
    step();
    wait_ready();
    dl_wr_i = 1'b1;
    dl_addr_i = 8'h7E;
    dl_data_i = 8'h81;
    step();
    dl_wr_i = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_req req=%b expected 1", mem_if.mem_req);
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b0 || pump_o !== 8'h3F || core_reset_o !== 1'b1 ||
        byte_count_o !== 9'd0 || dl_wait_o !== 1'b1 || mem_if.mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid req=%b pump=%h core_reset=%b cnt=%0d wait=%b addr=%h",
               mem_if.mem_req, pump_o, core_reset_o, byte_count_o, dl_wait_o, mem_if.mem_addr);
    end
    // download held high through the hold-off must have no effect
    poweron_run(1'b1);
  endtask

  initial begin
    mem_if.mem_ack = 1'b0;
    test_reset();
    test_download();
    test_random_downloads();
    test_timeout();
    test_wr_with_fall();
    test_redownload();
    test_wr_in_write();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
